lcd_text_ctrl: RTL and testbench
================================

LCD_TEXT_CTRL -- requirements
Module: lcd_text_ctrl

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 8, meaning LCD data bus mode (8 or 4 bits; any other value is illegal).
REQ-002 SHALL have parameter COLS, default 16, meaning characters per display row (1..40).
REQ-003 SHALL have parameter ROWS, default 2, meaning display rows (1, 2 or 4).
REQ-004 SHALL have parameter FIFO_DEPTH, default 16, meaning character buffer entries (power of 2, ≥2).
REQ-005 SHALL have parameter EN_HIGH, default 12, meaning clocks lcd_en is held high per pulse (≥1).
REQ-006 SHALL have parameter CMD_WAIT, default 2000, meaning idle clocks after a normal command or character transfer.
REQ-007 SHALL have parameter CLR_WAIT, default 80000, meaning idle clocks after a clear command (0x01).
REQ-008 SHALL have parameter POR_WAIT, default 750000, meaning clocks waited after reset release before the first transfer.
REQ-009 SHALL have ports: clk in 1 (sole clock, rising edge); reset_n in 1 (asynchronous, active-low reset).
REQ-010 SHALL have ports: char_valid in 1 (char offered); char_data in 8 (ASCII code); char_ready out 1 (char accepted when char_valid && char_ready).
REQ-011 SHALL have ports: clr_req in 1 (single-cycle clear pulse); init_done out 1 (init sequence complete); busy out 1 (transfer/wait in progress).
REQ-012 SHALL have ports: lcd_data out 8 (in 4-bit mode, nibble on [7:4], [3:0]=0); lcd_rs out 1; lcd_rw out 1 (always 0); lcd_en out 1.

Function
REQ-013 SHALL buffer chars in a FIFO_DEPTH FIFO; char_ready = init_done && !full; a push into a full FIFO is impossible; pop only when the FSM starts a character transfer.
REQ-014 SHALL implement FSM states POR, INIT, IDLE, SETUP, PULSE, HOLD, WAIT; 4-bit mode repeats SETUP/PULSE/HOLD for the low nibble before WAIT.
REQ-015 Transfer timing SHALL be: SETUP 1 clk (rs/data driven, en=0); PULSE EN_HIGH clks (en=1); HOLD 1 clk (en=0, data/rs unchanged); WAIT CMD_WAIT clks, or CLR_WAIT clks if the byte was 0x01 with rs=0.
REQ-016 POR SHALL last POR_WAIT clks after reset release, then go to INIT.
REQ-017 INIT SHALL send commands 0x38 (8-bit) or 0x28 (4-bit, preceded by a single nibble 0x2 pulse with CMD_WAIT), then 0x0C, 0x06, 0x01, all rs=0.
REQ-018 init_done SHALL assert in the first clock of IDLE after the CLR_WAIT of the init clear and stay high until reset.
REQ-019 IDLE priority SHALL be: pending clear > pending cursor command > FIFO char.
REQ-020 clr_req SHALL latch a clear pending flag at any time after init_done; the flag is serviced at the next IDLE by sending 0x01 and setting cursor to row 0, col 0; FIFO contents are retained.
REQ-021 Cursor SHALL be tracked as row/col; each written char increments col; when col reaches COLS, col=0, row=(row+1) mod ROWS and a set-address command 0x80|base(row) is pending, with base = 0x00, 0x40, 0x14, 0x54 for rows 0..3.
REQ-022 char 0x0A SHALL be popped but not written: col=0, row advances as in REQ-021, and an address command is pending.
REQ-023 busy SHALL be 1 in every state except IDLE; multiple clr_req pulses during one busy period SHALL cause a single clear.

Reset
REQ-024 While reset_n=0 SHALL hold: lcd_data=0, lcd_rs=0, lcd_rw=0, lcd_en=0, char_ready=0, init_done=0, busy=0, FIFO empty, cursor 0/0, clear flag 0, state POR.
REQ-025 Reset asserted mid-transfer SHALL drop lcd_en to 0 immediately (asynchronously) and restart from POR on release.

Verification
REQ-026 BUS_WIDTH=8, EN_HIGH=2, CMD_WAIT=3, CLR_WAIT=10, POR_WAIT=5: release reset -> first en rise at clk 7 with data 0x38; then 0x0C, 0x06, 0x01; each en pulse is 2 clks; init_done rises 10+1 clks after the clear HOLD.
REQ-027 BUS_WIDTH=4: push 'A' (0x41) -> two en pulses with lcd_data 0x40 then 0x10, rs=1.
REQ-028 COLS=4, ROWS=2: push "ABCDE" -> A,B,C,D written, command 0x C0 (rs=0), then E written.
REQ-029 FIFO_DEPTH=4 with display stalled: push 5 chars -> char_ready=0 after 4th accept; no char lost or duplicated.
REQ-030 clr_req mid char transfer -> transfer completes, 0x01 sent next with CLR_WAIT wait, next char written at row 0 col 0.
REQ-031 reset_n low during PULSE -> lcd_en=0 in the same cycle; full init sequence repeats after release.

Source files
------------

// File: rtl/lcd_text_ctrl.sv
// lcd_text_ctrl
// -------------
// Character-stream front end for an HD44780-style text LCD. After reset it
// waits for the panel's power-on delay, runs the init sequence, then writes
// characters from a small FIFO. It tracks the cursor so that it can insert
// DDRAM set-address commands on line wrap and newline. It also services
// asynchronous clear requests.
//
// Ports
//   clk         sole clock, rising edge
//   reset_n     asynchronous active-low reset
//   char_valid  character offered on char_data
//   char_data   ASCII code (0x0A = newline, never written to the panel)
//   char_ready  FIFO can take a character
//   clr_req     single-cycle clear request (honoured once init_done is high)
//   init_done   init sequence complete; sticky until reset
//   busy        FSM is anywhere but IDLE
//   lcd_data    panel data bus (4-bit mode: nibble on [7:4], [3:0] = 0)
//   lcd_rs      register select (0 = command, 1 = data)
//   lcd_rw      always 0 (write only)
//   lcd_en      enable strobe
//   dbg_state_o current FSM state encoding
//
// Handshake: a character moves into the FIFO on every rising clk edge where
// char_valid && char_ready. char_data must be stable while char_valid is
// high. char_ready depends only on registered state, never on char_valid.

module lcd_text_ctrl #(
  parameter int unsigned BUS_WIDTH  = 8,
  parameter int unsigned COLS       = 16,
  parameter int unsigned ROWS       = 2,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned EN_HIGH    = 12,
  parameter int unsigned CMD_WAIT   = 2000,
  parameter int unsigned CLR_WAIT   = 80000,
  parameter int unsigned POR_WAIT   = 750000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       char_valid,
  input  logic [7:0] char_data,
  output logic       char_ready,
  input  logic       clr_req,
  output logic       init_done,
  output logic       busy,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic [2:0] dbg_state_o
);

  typedef enum logic [2:0] {
    ST_POR   = 3'd0,
    ST_INIT  = 3'd1,
    ST_IDLE  = 3'd2,
    ST_SETUP = 3'd3,
    ST_PULSE = 3'd4,
    ST_HOLD  = 3'd5,
    ST_WAIT  = 3'd6
  } state_e;

  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE  = 1;
  // Counters compare against "last" values so an N-clock phase lasts exactly N clocks.
  localparam logic [31:0] POR_LAST = (POR_WAIT > 0) ? 32'(POR_WAIT - 1) : 32'd0;
  localparam logic [31:0] EN_LAST  = (EN_HIGH  > 0) ? 32'(EN_HIGH  - 1) : 32'd0;
  localparam logic [31:0] CMD_LAST = (CMD_WAIT > 0) ? 32'(CMD_WAIT - 1) : 32'd0;
  localparam logic [31:0] CLR_LAST = (CLR_WAIT > 0) ? 32'(CLR_WAIT - 1) : 32'd0;
  // 4-bit mode has one extra leading step: the lone 0x2 nibble.
  localparam logic [2:0]  NUM_INIT = (BUS_WIDTH == 4) ? 3'd5 : 3'd4;
  localparam logic [5:0]  COLS_M1  = 6'(COLS - 1);
  localparam logic [1:0]  ROWS_M1  = 2'(ROWS - 1);
  localparam bit          NIBBLE   = (BUS_WIDTH == 4);

  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    logic [7:0] c;
    c = 8'h01;
    if (NIBBLE) begin
      case (idx)
        3'd0:    c = 8'h20;  // only the high nibble (0x2) goes out
        3'd1:    c = 8'h28;
        3'd2:    c = 8'h0C;
        3'd3:    c = 8'h06;
        default: c = 8'h01;
      endcase
    end else begin
      case (idx)
        3'd0:    c = 8'h38;
        3'd1:    c = 8'h0C;
        3'd2:    c = 8'h06;
        default: c = 8'h01;
      endcase
    end
    return c;
  endfunction

  function automatic logic [7:0] row_base(input logic [1:0] row);
    logic [7:0] b;
    case (row)
      2'd0:    b = 8'h00;
      2'd1:    b = 8'h40;
      2'd2:    b = 8'h14;
      default: b = 8'h54;
    endcase
    return b;
  endfunction

  // ---------------------------------------------------------------- FIFO
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        fifo_full, fifo_empty, push, pop;
  logic [7:0]  fifo_head;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign fifo_head  = mem_q[rd_ptr_q[AW-1:0]];
  assign push       = char_valid && char_ready;
  assign wr_ptr_d   = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
  assign rd_ptr_d   = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= char_data;
  end

  // ---------------------------------------------------------------- FSM state
  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0]  byte_q, byte_d;
  logic        rs_q, rs_d;
  logic        lo_nib_q, lo_nib_d;     // second (low) nibble in flight
  logic        single_q, single_d;     // transfer is one nibble only
  logic [2:0]  init_idx_q, init_idx_d;
  logic        init_done_q, init_done_d;
  logic        clr_pend_q, clr_pend_d;
  logic        addr_pend_q, addr_pend_d;
  logic [1:0]  row_q, row_d;
  logic [5:0]  col_q, col_d;
  logic        clr_taken;
  logic [1:0]  next_row;
  logic [31:0] wait_last;

  assign next_row  = (row_q == ROWS_M1) ? 2'd0 : row_q + 2'd1;
  // The clear command needs the long wait only when it really is a command.
  assign wait_last = (byte_q == 8'h01 && !rs_q) ? CLR_LAST : CMD_LAST;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    byte_d      = byte_q;
    rs_d        = rs_q;
    lo_nib_d    = lo_nib_q;
    single_d    = single_q;
    init_idx_d  = init_idx_q;
    init_done_d = init_done_q;
    addr_pend_d = addr_pend_q;
    row_d       = row_q;
    col_d       = col_q;
    pop         = 1'b0;
    clr_taken   = 1'b0;

    case (state_q)
      ST_POR: begin
        if (cnt_q == POR_LAST) begin
          state_d = ST_INIT;
          cnt_d   = 32'd0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      ST_INIT: begin
        byte_d     = init_cmd(init_idx_q);
        rs_d       = 1'b0;
        lo_nib_d   = 1'b0;
        single_d   = NIBBLE && (init_idx_q == 3'd0);
        init_idx_d = init_idx_q + 3'd1;
        state_d    = ST_SETUP;
      end

      ST_IDLE: begin
        lo_nib_d = 1'b0;
        single_d = 1'b0;
        if (clr_pend_q) begin
          // Clear also homes the panel's address, so any pending
          // set-address command is redundant.
          byte_d      = 8'h01;
          rs_d        = 1'b0;
          row_d       = 2'd0;
          col_d       = 6'd0;
          addr_pend_d = 1'b0;
          clr_taken   = 1'b1;
          state_d     = ST_SETUP;
        end else if (addr_pend_q) begin
          byte_d      = 8'h80 | row_base(row_q);
          rs_d        = 1'b0;
          addr_pend_d = 1'b0;
          state_d     = ST_SETUP;
        end else if (!fifo_empty) begin
          pop = 1'b1;
          if (fifo_head == 8'h0A) begin
            // Newline is consumed here and never reaches the panel.
            col_d       = 6'd0;
            row_d       = next_row;
            addr_pend_d = 1'b1;
          end else begin
            byte_d  = fifo_head;
            rs_d    = 1'b1;
            state_d = ST_SETUP;
            if (col_q == COLS_M1) begin
              col_d       = 6'd0;
              row_d       = next_row;
              addr_pend_d = 1'b1;
            end else begin
              col_d = col_q + 6'd1;
            end
          end
        end
      end

      ST_SETUP: begin
        state_d = ST_PULSE;
        cnt_d   = 32'd0;
      end

      ST_PULSE: begin
        if (cnt_q == EN_LAST) begin
          state_d = ST_HOLD;
          cnt_d   = 32'd0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      ST_HOLD: begin
        cnt_d = 32'd0;
        if (NIBBLE && !single_q && !lo_nib_q) begin
          lo_nib_d = 1'b1;
          state_d  = ST_SETUP;
        end else begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (cnt_q == wait_last) begin
          cnt_d = 32'd0;
          if (init_done_q) begin
            state_d = ST_IDLE;
          end else if (init_idx_q == NUM_INIT) begin
            state_d     = ST_IDLE;
            init_done_d = 1'b1;
          end else begin
            state_d = ST_INIT;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      default: begin
        state_d = ST_POR;
        cnt_d   = 32'd0;
      end
    endcase

    // A request that coincides with servicing is covered by that clear, so
    // any number of pulses between two IDLE visits collapses into one clear.
    clr_pend_d = clr_taken ? 1'b0 : (clr_pend_q | (clr_req & init_done_q));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_POR;
      cnt_q       <= 32'd0;
      byte_q      <= 8'h00;
      rs_q        <= 1'b0;
      lo_nib_q    <= 1'b0;
      single_q    <= 1'b0;
      init_idx_q  <= 3'd0;
      init_done_q <= 1'b0;
      clr_pend_q  <= 1'b0;
      addr_pend_q <= 1'b0;
      row_q       <= 2'd0;
      col_q       <= 6'd0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      byte_q      <= byte_d;
      rs_q        <= rs_d;
      lo_nib_q    <= lo_nib_d;
      single_q    <= single_d;
      init_idx_q  <= init_idx_d;
      init_done_q <= init_done_d;
      clr_pend_q  <= clr_pend_d;
      addr_pend_q <= addr_pend_d;
      row_q       <= row_d;
      col_q       <= col_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  // ---------------------------------------------------------------- outputs
  // Bus outputs are decoded from registers. Because lcd_en comes straight
  // from state_q, it falls as soon as reset_n goes low.
  assign lcd_en      = (state_q == ST_PULSE);
  assign lcd_rs      = rs_q;
  assign lcd_rw      = 1'b0;
  assign lcd_data    = !NIBBLE  ? byte_q :
                       lo_nib_q ? {byte_q[3:0], 4'h0} : {byte_q[7:4], 4'h0};
  assign busy        = reset_n && (state_q != ST_IDLE);
  assign init_done   = init_done_q;
  assign char_ready  = init_done_q && !fifo_full;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_lcd_text_ctrl.sv
module tb_lcd_text_ctrl;

  // ------------------------------------------------------------ clock/reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  // 8-bit instance: COLS=4, ROWS=2, FIFO_DEPTH=4
  logic       cv8, clr8;
  logic [7:0] cd8;
  logic       ready8, done8, busy8, rs8, rw8, en8;
  logic [7:0] d8;
  logic [2:0] st8;
  // 4-bit instance, same geometry and timing
  logic       cv4, clr4;
  logic [7:0] cd4;
  logic       ready4, done4, busy4, rs4, rw4, en4;
  logic [7:0] d4;
  logic [2:0] st4;

  lcd_text_ctrl #(.BUS_WIDTH(8), .COLS(4), .ROWS(2), .FIFO_DEPTH(4), .EN_HIGH(2),
                  .CMD_WAIT(3), .CLR_WAIT(10), .POR_WAIT(5)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .char_valid(cv8), .char_data(cd8),
    .char_ready(ready8), .clr_req(clr8), .init_done(done8), .busy(busy8),
    .lcd_data(d8), .lcd_rs(rs8), .lcd_rw(rw8), .lcd_en(en8), .dbg_state_o(st8)
  );

  lcd_text_ctrl #(.BUS_WIDTH(4), .COLS(4), .ROWS(2), .FIFO_DEPTH(4), .EN_HIGH(2),
                  .CMD_WAIT(3), .CLR_WAIT(10), .POR_WAIT(5)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .char_valid(cv4), .char_data(cd4),
    .char_ready(ready4), .clr_req(clr4), .init_done(done4), .busy(busy4),
    .lcd_data(d4), .lcd_rs(rs4), .lcd_rw(rw4), .lcd_en(en4), .dbg_state_o(st4)
  );

  // ------------------------------------------------------------ bus monitors
  int unsigned cyc;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  logic [8:0]  obs8_q[$];
  int unsigned rise8_q[$];
  int unsigned wid8_q[$];
  logic [8:0]  obs4_q[$];
  logic        en8_prev, en4_prev;
  int unsigned w8;
  logic [8:0]  cur8;
  int unsigned unstable8 = 0;
  int unsigned rw_bad = 0;

  always @(negedge clk) begin
    if (rw8 !== 1'b0 || rw4 !== 1'b0) rw_bad <= rw_bad + 1;
    if (!reset_n) begin
      obs8_q.delete(); rise8_q.delete(); wid8_q.delete(); obs4_q.delete();
      en8_prev <= 1'b0; en4_prev <= 1'b0; w8 <= 0; cur8 <= '0;
    end else begin
      if (en8 && !en8_prev) begin
        obs8_q.push_back({rs8, d8});
        rise8_q.push_back(cyc);
        cur8 <= {rs8, d8};
        w8   <= 1;
      end else if (en8) begin
        w8 <= w8 + 1;
        if ({rs8, d8} !== cur8) unstable8 <= unstable8 + 1;
      end else if (en8_prev) begin
        wid8_q.push_back(w8);
      end
      if (en4 && !en4_prev) obs4_q.push_back({rs4, d4});
      en8_prev <= en8;
      en4_prev <= en4;
    end
  end

  // ------------------------------------------------------------ scoreboard
  int          checks = 0;
  int          errors = 0;
  logic [8:0]  exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_bus(input int which, input string tag);
    logic [8:0]  o, e;
    int unsigned w;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (which == 8) begin
        if (obs8_q.size() > 0) o = obs8_q.pop_front(); else o = 'x;
        if (wid8_q.size() > 0) w = wid8_q.pop_front(); else w = 0;
        check({tag, "_en_width"}, w, 32'd2);
      end else begin
        if (obs4_q.size() > 0) o = obs4_q.pop_front(); else o = 'x;
      end
      check(tag, 32'(o), 32'(e));
    end
    if (which == 8) check({tag, "_extra"}, obs8_q.size(), 32'd0);
    else            check({tag, "_extra"}, obs4_q.size(), 32'd0);
    rise8_q.delete();
  endtask

  // ------------------------------------------------------------ drivers
  task automatic push_char(input int which, input logic [7:0] c);
    logic ok;
    ok = 1'b0;
    if (which == 8) begin cv8 = 1'b1; cd8 = c; end
    else            begin cv4 = 1'b1; cd4 = c; end
    for (int i = 0; i < 500; i++) begin
      ok = (which == 8) ? ready8 : ready4;
      @(negedge clk);
      if (ok) break;
    end
    cv8 = 1'b0;
    cv4 = 1'b0;
    check("push_accept", 32'(ok), 32'd1);
  endtask

  task automatic wait_idle(input int which);
    int quiet;
    logic b;
    quiet = 0;
    for (int i = 0; i < 2000 && quiet < 3; i++) begin
      @(negedge clk);
      b = (which == 8) ? busy8 : busy4;
      quiet = b ? 0 : quiet + 1;
    end
    check("idle_timeout", 32'(quiet >= 3), 32'd1);
  endtask

  task automatic wait_init(input int which);
    logic d;
    d = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      d = (which == 8) ? done8 : done4;
      if (d) break;
    end
    check("init_timeout", 32'(d), 32'd1);
  endtask

  task automatic wait_en8();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (en8) break;
    end
    check("en_seen", 32'(en8), 32'd1);
  endtask

  task automatic pulse_clr8();
    clr8 = 1'b1;
    @(negedge clk);
    clr8 = 1'b0;
  endtask

  task automatic check_init8_timing(input string tag);
    int unsigned exp_rise [4];
    int unsigned r;
    exp_rise = '{7, 15, 23, 31};
    for (int i = 0; i < 4; i++) begin
      if (rise8_q.size() > i) r = rise8_q[i]; else r = 0;
      check({tag, "_rise"}, r, exp_rise[i]);
    end
  endtask

  // ------------------------------------------------------------ stimulus
  int unsigned r0, r1, r2;

  initial begin
    reset_n = 1'b0;
    cv8 = 1'b0; cd8 = 8'h00; clr8 = 1'b0;
    cv4 = 1'b0; cd4 = 8'h00; clr4 = 1'b0;
    repeat (3) @(negedge clk);

    // Outputs held quiet in reset
    check("rst_en",    32'(en8),    32'd0);
    check("rst_data",  32'(d8),     32'd0);
    check("rst_rs",    32'(rs8),    32'd0);
    check("rst_ready", 32'(ready8), 32'd0);
    check("rst_done",  32'(done8),  32'd0);
    check("rst_busy",  32'(busy8),  32'd0);
    check("rst_busy4", 32'(busy4),  32'd0);
    check("rst_data4", 32'(d4),     32'd0);

    // Power-on wait and init sequence (8-bit)
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("por_busy",  32'(busy8),  32'd1);
    check("por_ready", 32'(ready8), 32'd0);
    check("por_en",    32'(en8),    32'd0);
    wait_init(8);
    check("init_done_cycle", cyc, 32'd44);
    check("post_init_busy",  32'(busy8),  32'd0);
    check("post_init_ready", 32'(ready8), 32'd1);
    check_init8_timing("init8");
    exp_q.push_back(9'h038); exp_q.push_back(9'h00C);
    exp_q.push_back(9'h006); exp_q.push_back(9'h001);
    check_bus(8, "init8");

    // 4-bit init: lone 0x2 nibble, then 0x28, 0x0C, 0x06, 0x01 as nibble pairs
    wait_init(4);
    check("init4_done_cycle", cyc, 32'd68);
    exp_q.push_back(9'h020);
    exp_q.push_back(9'h020); exp_q.push_back(9'h080);
    exp_q.push_back(9'h000); exp_q.push_back(9'h0C0);
    exp_q.push_back(9'h000); exp_q.push_back(9'h060);
    exp_q.push_back(9'h000); exp_q.push_back(9'h010);
    check_bus(4, "init4");

    // 4-bit character 'A'
    push_char(4, 8'h41);
    wait_idle(4);
    exp_q.push_back(9'h140); exp_q.push_back(9'h110);
    check_bus(4, "char4_A");

    // Clear stalls the panel while "ABCDE" is offered: FIFO fills after D,
    // then wrap at COLS=4 inserts 0xC0 before E.
    pulse_clr8();
    push_char(8, "A");
    push_char(8, "B");
    push_char(8, "C");
    push_char(8, "D");
    check("full_ready", 32'(ready8), 32'd0);
    push_char(8, "E");
    wait_idle(8);
    if (rise8_q.size() >= 3) begin r0 = rise8_q[0]; r1 = rise8_q[1]; r2 = rise8_q[2]; end
    else begin r0 = 0; r1 = 0; r2 = 0; end
    check("clr_wait_gap",  r1 - r0, 32'd15);
    check("char_wait_gap", r2 - r1, 32'd8);
    exp_q.push_back(9'h001);
    exp_q.push_back(9'h141); exp_q.push_back(9'h142);
    exp_q.push_back(9'h143); exp_q.push_back(9'h144);
    exp_q.push_back(9'h0C0); exp_q.push_back(9'h145);
    check_bus(8, "abcde");

    // Two clear pulses during F's transfer -> one clear, cursor homed:
    // G,H,I land on row 0 cols 0..2, J fills col 3 and wraps to row 1.
    push_char(8, "F");
    wait_en8();
    pulse_clr8();
    check("busy_mid_xfer", 32'(busy8), 32'd1);
    @(negedge clk);
    pulse_clr8();
    push_char(8, "G");
    push_char(8, "H");
    push_char(8, "I");
    push_char(8, "J");
    wait_idle(8);
    if (rise8_q.size() >= 3) begin r1 = rise8_q[1]; r2 = rise8_q[2]; end
    else begin r1 = 0; r2 = 0; end
    check("clr2_wait_gap", r2 - r1, 32'd15);
    exp_q.push_back(9'h146); exp_q.push_back(9'h001);
    exp_q.push_back(9'h147); exp_q.push_back(9'h148);
    exp_q.push_back(9'h149); exp_q.push_back(9'h14A);
    exp_q.push_back(9'h0C0);
    check_bus(8, "clr_mid");

    // Newline from row 1: back to row 0, address 0x80, then K
    push_char(8, 8'h0A);
    push_char(8, "K");
    wait_idle(8);
    exp_q.push_back(9'h080); exp_q.push_back(9'h14B);
    check_bus(8, "newline");

    // Reset during PULSE: en drops without a clock edge, then init repeats
    push_char(8, "L");
    wait_en8();
    reset_n = 1'b0;
    #1;
    check("rst_async_en",   32'(en8),   32'd0);
    check("rst_async_busy", 32'(busy8), 32'd0);
    repeat (2) @(negedge clk);
    check("rst2_data",  32'(d8),     32'd0);
    check("rst2_ready", 32'(ready8), 32'd0);
    check("rst2_done",  32'(done8),  32'd0);
    reset_n = 1'b1;
    wait_init(8);
    check("reinit_done_cycle", cyc, 32'd44);
    check_init8_timing("reinit8");
    exp_q.push_back(9'h038); exp_q.push_back(9'h00C);
    exp_q.push_back(9'h006); exp_q.push_back(9'h001);
    check_bus(8, "reinit8");

    check("en_data_stable", unstable8, 32'd0);
    check("rw_low",         rw_bad,    32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
